i2c_mem_target: RTL and testbench

//  I2C target (slave) that lets an external I2C controller read and write an 11-bit byte-addressed memory.

---
 rtl/i2c_target_pkg.sv | 27 ++
 rtl/i2c_bus_sync.sv | 87 ++++++++
 rtl/i2c_mem_target.sv | 193 +++++++++++++++++++
 tb/tb_i2c_mem_target.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_target_pkg.sv
// Shared types and constants for the I2C memory target.
//   ADDR_W / DATA_W : memory address and data widths (24C16-style 11-bit space)
//   mem_addr_t      : memory byte address type
//   data_t          : byte type
//   state_e         : protocol FSM states
package i2c_target_pkg;

  localparam int ADDR_W = 11;
  localparam int DATA_W = 8;

  typedef logic [ADDR_W-1:0] mem_addr_t;
  typedef logic [DATA_W-1:0] data_t;

  typedef enum logic [3:0] {
    IDLE,
    DEV,
    DEV_ACK,
    WORD,
    WORD_ACK,
    WR,
    WR_ACK,
    RD,
    RD_ACK,
    IGNORE
  } state_e;

endpackage

// File: rtl/i2c_bus_sync.sv
// Bus input conditioning for the I2C target.
// Brings the asynchronous SCL/SDA pins into the clk domain and derives
// single-cycle bus event pulses from the conditioned levels.
// Optional macro: I2C_TARGET_FILTER_EN adds a FILTER_LEN-deep stability
// filter after the synchroniser (a level change is accepted only after
// FILTER_LEN equal consecutive samples).
// Ports:
//   clk, rst_n   : system clock, async active-low reset
//   scl_i, sda_i : raw bus pins
//   sda_o        : conditioned SDA level
//   scl_rise_o   : SCL 0->1 pulse
//   scl_fall_o   : SCL 1->0 pulse
//   start_o      : SDA fall while SCL high
//   stop_o       : SDA rise while SCL high
module i2c_bus_sync
  import i2c_target_pkg::*;
#(
  parameter int FILTER_LEN = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o
);

  // bit 1 = SCL, bit 0 = SDA; everything resets to the idle-bus level (high)
  logic [1:0] meta_q, sync_q, prev_q, lvl;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 2'b11;
      sync_q <= 2'b11;
    end else begin
      meta_q <= {scl_i, sda_i};
      sync_q <= meta_q;
    end
  end

`ifdef I2C_TARGET_FILTER_EN
  localparam int CW = $clog2(FILTER_LEN + 1);

  for (genvar g = 0; g < 2; g++) begin : g_filt
    logic [CW-1:0] cnt_q;
    logic          lvl_q;

    // cnt_q counts consecutive samples that disagree with the accepted level
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q <= '0;
        lvl_q <= 1'b1;
      end else if (sync_q[g] == lvl_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(FILTER_LEN - 1)) begin
        cnt_q <= '0;
        lvl_q <= sync_q[g];
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end

    assign lvl[g] = lvl_q;
  end
`else
  logic unused_flt;
  assign unused_flt = (FILTER_LEN > 0);
  assign lvl        = sync_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev_q <= 2'b11;
    else        prev_q <= lvl;
  end

  // START/STOP require SCL high on both samples so an SCL edge coinciding
  // with an SDA change is never mistaken for a bus condition
  assign sda_o      = lvl[0];
  assign scl_rise_o = lvl[1] & ~prev_q[1];
  assign scl_fall_o = ~lvl[1] & prev_q[1];
  assign start_o    = lvl[1] & prev_q[1] & prev_q[0] & ~lvl[0];
  assign stop_o     = lvl[1] & prev_q[1] & ~prev_q[0] & lvl[0];

endmodule

// File: rtl/i2c_mem_target.sv
// I2C target giving an external controller read/write access to an 11-bit
// byte-addressed RAM, 24C16 protocol: dev byte {DEV_ID, A[10:8], R/W},
// word byte A[7:0], then data bytes with address auto-increment (mod 2048).
// Optional macro: I2C_TARGET_FILTER_EN (glitch filter in i2c_bus_sync).
// Ports:
//   clk, rst_n   : system clock (>= 8x SCL), async active-low reset
//   scl_i, sda_i : bus pins (async)
//   sda_oe       : 1 = pull SDA low
//   mem_addr     : RAM byte address
//   mem_wdata    : RAM write data
//   mem_we       : 1-cycle write strobe
//   mem_re       : 1-cycle read strobe, mem_rdata valid one clk later
//   mem_rdata    : RAM read data
//   busy         : set on address match, cleared by STOP/START
module i2c_mem_target
  import i2c_target_pkg::*;
#(
  parameter logic [3:0] DEV_ID     = 4'b1010,
  parameter int         FILTER_LEN = 3
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      scl_i,
  input  logic      sda_i,
  output logic      sda_oe,
  output mem_addr_t mem_addr,
  output data_t     mem_wdata,
  output logic      mem_we,
  output logic      mem_re,
  input  data_t     mem_rdata,
  output logic      busy
);

  logic      sda_s, scl_rise, scl_fall, bus_start, bus_stop;
  state_e    state_q, state_d;
  logic [3:0] bitcnt_q;
  data_t     shreg_q, byte_in, wdata_q;
  mem_addr_t addr_q;
  logic      rw_q, rd_pend_q;
  logic      oe_q, oe_d, we_q, we_d, re_q, re_d, busy_q, busy_d;
  logic      last_bit, dev_match;

  i2c_bus_sync #(
    .FILTER_LEN (FILTER_LEN)
  ) u_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .scl_i      (scl_i),
    .sda_i      (sda_i),
    .sda_o      (sda_s),
    .scl_rise_o (scl_rise),
    .scl_fall_o (scl_fall),
    .start_o    (bus_start),
    .stop_o     (bus_stop)
  );

  // byte as it stands once the bit on this SCL rise is shifted in
  assign byte_in   = {shreg_q[DATA_W-2:0], sda_s};
  assign last_bit  = (bitcnt_q == 4'd7);
  assign dev_match = (byte_in[7:4] == DEV_ID);

  // ---------------- state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // ---------------- next state ----------------
  // ACK states span from the 8th SCL rise to the 9th SCL rise.
  always_comb begin
    state_d = state_q;
    if (bus_stop) begin
      state_d = IDLE;
    end else if (bus_start) begin
      state_d = DEV;
    end else if (scl_rise) begin
      case (state_q)
        DEV:      if (last_bit) state_d = dev_match ? DEV_ACK : IGNORE;
        DEV_ACK:  state_d = rw_q ? RD : WORD;
        WORD:     if (last_bit) state_d = WORD_ACK;
        WORD_ACK: state_d = WR;
        WR:       if (last_bit) state_d = WR_ACK;
        WR_ACK:   state_d = WR;
        RD:       if (last_bit) state_d = RD_ACK;
        RD_ACK:   state_d = sda_s ? IGNORE : RD;
        default:  state_d = state_q;
      endcase
    end
  end

  // ---------------- outputs ----------------
  // SDA only changes on SCL fall; the fall inside an ACK state starts the
  // ACK, the fall after it (next state) releases or drives the first data bit.
  always_comb begin
    oe_d   = oe_q;
    we_d   = 1'b0;
    re_d   = 1'b0;
    busy_d = busy_q;
    if (bus_stop || bus_start) begin
      oe_d   = 1'b0;
      busy_d = 1'b0;
    end else begin
      if (scl_fall) begin
        case (state_q)
          DEV_ACK, WORD_ACK, WR_ACK: oe_d = 1'b1;
          RD:                       oe_d = ~shreg_q[DATA_W-1];
          default:                  oe_d = 1'b0;
        endcase
      end
      if (scl_rise) begin
        case (state_q)
          DEV:     if (last_bit && dev_match) busy_d = 1'b1;
          DEV_ACK: re_d = rw_q;
          WR_ACK:  we_d = 1'b1;
          RD_ACK:  re_d = ~sda_s;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oe_q   <= 1'b0;
      we_q   <= 1'b0;
      re_q   <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      oe_q   <= oe_d;
      we_q   <= we_d;
      re_q   <= re_d;
      busy_q <= busy_d;
    end
  end

  // ---------------- datapath ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bitcnt_q  <= '0;
      shreg_q   <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rw_q      <= 1'b0;
      rd_pend_q <= 1'b0;
    end else begin
      rd_pend_q <= re_q;
      if (bus_start || bus_stop) begin
        // a partial byte is simply dropped
        bitcnt_q <= '0;
      end else begin
        // bump the address the cycle after the write strobe so the RAM
        // sees the strobe with the address it was meant for
        if (we_q)      addr_q  <= addr_q + mem_addr_t'(1);
        if (rd_pend_q) shreg_q <= mem_rdata;
        if (scl_rise) begin
          case (state_q)
            DEV, WORD, WR: begin
              shreg_q  <= byte_in;
              bitcnt_q <= bitcnt_q + 4'd1;
              if (last_bit) begin
                case (state_q)
                  DEV: if (dev_match) begin
                    addr_q[ADDR_W-1:8] <= byte_in[3:1];
                    rw_q               <= byte_in[0];
                  end
                  WORD:    addr_q[7:0] <= byte_in;
                  default: wdata_q     <= byte_in;
                endcase
              end
            end
            RD: begin
              shreg_q  <= {shreg_q[DATA_W-2:0], 1'b1};
              bitcnt_q <= bitcnt_q + 4'd1;
              // advance before the controller's ACK so a follow-on
              // mem_re already points at the next byte
              if (last_bit) addr_q <= addr_q + mem_addr_t'(1);
            end
            DEV_ACK, WORD_ACK, WR_ACK, RD_ACK: bitcnt_q <= '0;
            default: ;
          endcase
        end
      end
    end
  end

  assign sda_oe    = oe_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_we    = we_q;
  assign mem_re    = re_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_i2c_mem_target.sv
`timescale 1ns/1ps
module tb_i2c_mem_target;
  import i2c_target_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        scl_drv = 1'b1, sda_drv = 1'b1;
  logic        sda_line;
  logic        sda_oe, mem_we, mem_re, busy;
  logic [10:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;

  // open-drain SDA: controller and target both only pull low
  assign sda_line = sda_drv & ~sda_oe;

  always #5 clk = ~clk;

  i2c_mem_target dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .scl_i     (scl_drv),
    .sda_i     (sda_line),
    .sda_oe    (sda_oe),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_re    (mem_re),
    .mem_rdata (mem_rdata),
    .busy      (busy)
  );

  // ---------------- byte RAM model ----------------
  logic [7:0]  ram [0:2047];
  logic        pre_we = 1'b0;
  logic [10:0] pre_addr = '0;
  logic [7:0]  pre_data = '0;

  always @(posedge clk) begin
    if (pre_we) ram[pre_addr] <= pre_data;
    if (mem_we) ram[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= ram[mem_addr];
  end

  // ---------------- scoreboard ----------------
  typedef struct packed { logic [10:0] addr; logic [7:0] data; } wr_t;
  wr_t        wr_exp_q[$];
  logic [7:0] rd_exp_q[$];
  wr_t        mon_e;
  int n_cmp = 0, n_err = 0;
  int we_cnt = 0, re_cnt = 0, oe_cnt = 0;
  bit busy_seen = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (sda_oe) oe_cnt++;
      if (busy)   busy_seen = 1'b1;
      if (mem_re) re_cnt++;
      if (mem_we) begin
        we_cnt++;
        check("wr_pending", (wr_exp_q.size() != 0), 1);
        if (wr_exp_q.size() != 0) begin
          mon_e = wr_exp_q.pop_front();
          check("wr_addr", mem_addr, mon_e.addr);
          check("wr_data", mem_wdata, mon_e.data);
        end
      end
    end
  end

  // ---------------- I2C controller model ----------------
  // SCL period = 4 quarters of 10 clk
  task automatic wq();
    repeat (10) @(negedge clk);
  endtask

  task automatic i2c_start();
    if (!scl_drv) begin
      sda_drv = 1'b1; wq();
      scl_drv = 1'b1; wq();
    end
    sda_drv = 1'b0; wq();
    scl_drv = 1'b0; wq();
  endtask

  task automatic i2c_stop();
    sda_drv = 1'b0; wq();
    scl_drv = 1'b1; wq();
    sda_drv = 1'b1; wq();
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      sda_drv = b[i]; wq();
      scl_drv = 1'b1; wq(); wq();
      scl_drv = 1'b0; wq();
    end
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    send_bits(b, 8);
    sda_drv = 1'b1; wq();
    scl_drv = 1'b1; wq();
    ack = ~sda_line; wq();
    scl_drv = 1'b0; wq();
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      sda_drv = 1'b1; wq();
      scl_drv = 1'b1; wq();
      b[i] = sda_line; wq();
      scl_drv = 1'b0; wq();
    end
    sda_drv = nack; wq();
    scl_drv = 1'b1; wq(); wq();
    scl_drv = 1'b0; wq();
  endtask

  task automatic preload(input logic [10:0] a, input logic [7:0] d);
    pre_addr = a; pre_data = d; pre_we = 1'b1;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  task automatic wr_txn(input logic [10:0] a, input logic [7:0] d);
    logic ack;
    i2c_start();
    write_byte({4'hA, a[10:8], 1'b0}, ack); check("wr_dev_ack", ack, 1);
    write_byte(a[7:0], ack);                check("wr_word_ack", ack, 1);
    wr_exp_q.push_back({a, d});
    write_byte(d, ack);                     check("wr_data_ack", ack, 1);
    i2c_stop();
  endtask

  task automatic rd_txn(input logic [10:0] a, input logic [7:0] d);
    logic ack;
    logic [7:0] got;
    i2c_start();
    write_byte({4'hA, a[10:8], 1'b0}, ack); check("rd_dev_ack", ack, 1);
    write_byte(a[7:0], ack);                check("rd_word_ack", ack, 1);
    i2c_start();
    write_byte({4'hA, a[10:8], 1'b1}, ack); check("rd_dev2_ack", ack, 1);
    rd_exp_q.push_back(d);
    read_byte(1'b1, got);
    check("rd_data", got, rd_exp_q.pop_front());
    i2c_stop();
  endtask

  typedef struct { logic [10:0] addr; logic [7:0] data; } vec_t;
  vec_t vecs [6];

  initial begin
    #900_000;
    $display("FAIL watchdog: run did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic ack;
    logic [7:0] got;
    int we0, re0, oe0;

    vecs[0] = '{addr: 11'h000, data: 8'h3C};
    vecs[1] = '{addr: 11'h7FF, data: 8'hC3};
    vecs[2] = '{addr: 11'h2AA, data: 8'h55};
    vecs[3] = '{addr: 11'h555, data: 8'hAA};
    vecs[4] = '{addr: 11'h0FF, data: 8'h01};
    vecs[5] = '{addr: 11'h400, data: 8'hFE};

    // reset state
    repeat (5) @(negedge clk);
    check("rst_sda_oe", sda_oe, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_we", mem_we, 0);
    check("rst_re", mem_re, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // 1: single write
    we0 = we_cnt;
    i2c_start();
    write_byte(8'hA2, ack); check("t1_dev_ack", ack, 1);
    check("t1_busy", busy, 1);
    write_byte(8'h05, ack); check("t1_word_ack", ack, 1);
    wr_exp_q.push_back({11'h105, 8'hA5});
    write_byte(8'hA5, ack); check("t1_data_ack", ack, 1);
    i2c_stop(); wq();
    check("t1_busy_after_stop", busy, 0);
    check("t1_we_count", we_cnt - we0, 1);

    // 2: random read with repeated START
    preload(11'h105, 8'h5A);
    re0 = re_cnt;
    rd_txn(11'h105, 8'h5A);
    check("t2_re_count", re_cnt - re0, 1);

    // 3: sequential write across the 0x7FF -> 0x000 wrap
    i2c_start();
    write_byte(8'hAE, ack); check("t3_dev_ack", ack, 1);
    write_byte(8'hFF, ack); check("t3_word_ack", ack, 1);
    wr_exp_q.push_back({11'h7FF, 8'h11});
    write_byte(8'h11, ack); check("t3_d0_ack", ack, 1);
    wr_exp_q.push_back({11'h000, 8'h22});
    write_byte(8'h22, ack); check("t3_d1_ack", ack, 1);
    i2c_stop(); wq();
    check("t3_addr_after_wrap", mem_addr, 11'h001);

    // 4: address miss
    we0 = we_cnt; re0 = re_cnt; oe0 = oe_cnt; busy_seen = 1'b0;
    i2c_start();
    write_byte(8'h90, ack); check("t4_nack", ack, 0);
    write_byte(8'h12, ack); check("t4_data_nack", ack, 0);
    i2c_stop(); wq();
    check("t4_oe_never", oe_cnt - oe0, 0);
    check("t4_no_we", we_cnt - we0, 0);
    check("t4_no_re", re_cnt - re0, 0);
    check("t4_busy_never", busy_seen, 0);

    // 5: STOP after 4 data bits
    we0 = we_cnt;
    i2c_start();
    write_byte(8'hA2, ack); check("t5_dev_ack", ack, 1);
    write_byte(8'h40, ack); check("t5_word_ack", ack, 1);
    send_bits(8'hF0, 4);
    i2c_stop(); wq();
    check("t5_no_we", we_cnt - we0, 0);
    check("t5_oe", sda_oe, 0);
    check("t5_idle", dut.state_q == IDLE, 1);
    check("t5_busy", busy, 0);
    wr_txn(11'h140, 8'h77);
    rd_txn(11'h140, 8'h77);

    // table: writes then read-back
    foreach (vecs[i]) wr_txn(vecs[i].addr, vecs[i].data);
    foreach (vecs[i]) rd_txn(vecs[i].addr, vecs[i].data);

    // 6: reset while the target drives a 0 data bit
    preload(11'h300, 8'h00);
    i2c_start();
    write_byte(8'hA6, ack); check("t6_dev_ack", ack, 1);
    write_byte(8'h00, ack); check("t6_word_ack", ack, 1);
    i2c_start();
    write_byte(8'hA7, ack); check("t6_dev2_ack", ack, 1);
    check("t6_driving_low", sda_oe, 1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_oe", sda_oe, 0);
    check("t6_rst_addr", mem_addr, 0);
    check("t6_rst_wdata", mem_wdata, 0);
    check("t6_rst_we", mem_we, 0);
    check("t6_rst_re", mem_re, 0);
    check("t6_rst_busy", busy, 0);
    scl_drv = 1'b1; sda_drv = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    wr_txn(11'h300, 8'h81);
    rd_txn(11'h300, 8'h81);

    wq();
    check("wr_queue_drained", wr_exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
